// File: rtl/gayle_xfer_ctrl.sv
// gayle_xfer_ctrl: sector transfer sequencer between CPU data register, host service side and a sector FIFO.
module gayle_xfer_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk7_en,
    input  logic       i_cmd_start,
    input  logic       i_cmd_dir,
    input  logic [7:0] i_cmd_count,
    input  logic       i_abort,
    input  logic       i_irq_ack,
    input  logic       i_cpu_rd,
    input  logic       i_cpu_wr,
    input  logic       i_hps_rd,
    input  logic       i_hps_wr,
    input  logic       i_fifo_full,
    input  logic       i_fifo_empty,
    input  logic       i_fifo_last,
    output logic       o_fifo_rd,
    output logic       o_fifo_wr,
    output logic       o_fifo_reset,
    output logic       o_drq,
    output logic       o_hps_req,
    output logic       o_busy,
    output logic       o_irq,
    output logic [8:0] o_sectors_left
);
    typedef enum logic [2:0] {S_IDLE, S_RD_WAIT, S_RD_XFER, S_WR_XFER, S_WR_DRAIN, S_DONE} state_t;

    state_t     r_state, w_next;
    logic [8:0] r_left, w_left, w_dec;
    logic [7:0] r_wcnt, w_wcnt;
    logic       r_irq, w_irq, r_fres, w_fres;
    logic       w_unused;

    assign w_unused = i_fifo_empty;
    // Saturating decrement so the sector count can never wrap below zero.
    assign w_dec = (r_left == 9'd0) ? 9'd0 : r_left - 9'd1;

    always_comb begin
        w_next = r_state;
        w_left = r_left;
        w_wcnt = r_wcnt;
        w_irq  = r_irq & ~i_irq_ack;
        w_fres = 1'b0;
        case (r_state)
            S_IDLE: if (i_cmd_start) begin
                w_left = (i_cmd_count == 8'd0) ? 9'd256 : {1'b0, i_cmd_count};
                w_fres = 1'b1;
                w_irq  = 1'b0;
                w_wcnt = 8'd0;
                w_next = i_cmd_dir ? S_WR_XFER : S_RD_WAIT;
            end
            S_RD_WAIT: if (i_fifo_full) begin
                w_next = S_RD_XFER;
                w_irq  = 1'b1;
            end
            S_RD_XFER: if (i_cpu_rd && i_fifo_last) begin
                w_left = w_dec;
                w_next = (w_dec == 9'd0) ? S_DONE : S_RD_WAIT;
            end
            S_WR_XFER: if (i_cpu_wr) begin
                w_wcnt = r_wcnt + 8'd1;
                w_next = (r_wcnt == 8'hff) ? S_WR_DRAIN : S_WR_XFER;
            end
            S_WR_DRAIN: if (i_hps_rd && i_fifo_last) begin
                w_left = w_dec;
                w_wcnt = 8'd0;
                w_next = (w_dec == 9'd0) ? S_DONE : S_WR_XFER;
                w_irq  = (w_dec == 9'd0) ? w_irq : 1'b1;
            end
            S_DONE: begin
                w_irq  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort overrides whatever the state decided this cycle, but leaves irq alone.
        if (i_abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
            w_left = 9'd0;
            w_wcnt = 8'd0;
            w_fres = 1'b1;
            w_irq  = r_irq & ~i_irq_ack;
        end
    end

    always_ff @(posedge clk) begin
        if (i_clk7_en) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_left  <= 9'd0;
                r_wcnt  <= 8'd0;
                r_irq   <= 1'b0;
                r_fres  <= 1'b1;
            end else begin
                r_state <= w_next;
                r_left  <= w_left;
                r_wcnt  <= w_wcnt;
                r_irq   <= w_irq;
                r_fres  <= w_fres;
            end
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_drq          = (r_state == S_RD_XFER) || (r_state == S_WR_XFER);
    assign o_hps_req      = (r_state == S_RD_WAIT) || (r_state == S_WR_DRAIN);
    assign o_fifo_wr      = (((r_state == S_RD_WAIT) || (r_state == S_RD_XFER)) && i_hps_wr) ||
                            ((r_state == S_WR_XFER) && i_cpu_wr);
    assign o_fifo_rd      = ((r_state == S_RD_XFER) && i_cpu_rd) || ((r_state == S_WR_DRAIN) && i_hps_rd);
    assign o_fifo_reset   = r_fres;
    assign o_irq          = r_irq;
    assign o_sectors_left = r_left;
endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// tb_gayle_xfer_ctrl: directed sequence of read/write/abort/reset scenarios with hand-computed expectations.
module tb_gayle_xfer_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0, clk7_en = 1'b1;
    logic       cmd_start = 1'b0, cmd_dir = 1'b0;
    logic [7:0] cmd_count = 8'd0;
    logic       abort = 1'b0, irq_ack = 1'b0;
    logic       cpu_rd = 1'b0, cpu_wr = 1'b0, hps_rd = 1'b0, hps_wr = 1'b0;
    logic       fifo_full = 1'b0, fifo_empty = 1'b1, fifo_last = 1'b0;
    logic       fifo_rd, fifo_wr, fifo_reset, drq, hps_req, busy, irq;
    logic [8:0] sectors_left;
    int         checks = 0, errors = 0;

    gayle_xfer_ctrl dut (
        .clk(clk), .reset(reset), .i_clk7_en(clk7_en), .i_cmd_start(cmd_start), .i_cmd_dir(cmd_dir),
        .i_cmd_count(cmd_count), .i_abort(abort), .i_irq_ack(irq_ack), .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr),
        .i_hps_rd(hps_rd), .i_hps_wr(hps_wr), .i_fifo_full(fifo_full), .i_fifo_empty(fifo_empty),
        .i_fifo_last(fifo_last), .o_fifo_rd(fifo_rd), .o_fifo_wr(fifo_wr), .o_fifo_reset(fifo_reset),
        .o_drq(drq), .o_hps_req(hps_req), .o_busy(busy), .o_irq(irq), .o_sectors_left(sectors_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic dir, input logic [7:0] cnt);
        cmd_start = 1'b1; cmd_dir = dir; cmd_count = cnt;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic fill_sector();
        hps_wr = 1'b1;
        repeat (256) tick();
        hps_wr = 1'b0;
        fifo_full = 1'b1;
        tick();
        fifo_full = 1'b0;
    endtask

    task automatic cpu_reads(input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            cpu_rd = 1'b1; fifo_last = last && (i == n - 1);
            tick();
        end
        cpu_rd = 1'b0; fifo_last = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", {8'd0, busy}, 9'd0);
        chk("rst_drq", {8'd0, drq}, 9'd0);
        chk("rst_hps_req", {8'd0, hps_req}, 9'd0);
        chk("rst_irq", {8'd0, irq}, 9'd0);
        chk("rst_left", sectors_left, 9'd0);
        chk("rst_fifo_reset", {8'd0, fifo_reset}, 9'd1);
        tick();
        chk("fifo_reset_pulse_end", {8'd0, fifo_reset}, 9'd0);
        cpu_wr = 1'b1; hps_rd = 1'b1; #1;
        chk("idle_drop_wr", {8'd0, fifo_wr}, 9'd0);
        chk("idle_drop_rd", {8'd0, fifo_rd}, 9'd0);
        cpu_wr = 1'b0; hps_rd = 1'b0;

        // two-sector read
        start(1'b0, 8'd2);
        chk("rd_start_left", sectors_left, 9'd2);
        chk("rd_start_fres", {8'd0, fifo_reset}, 9'd1);
        chk("rd_wait_hps_req", {8'd0, hps_req}, 9'd1);
        chk("rd_wait_drq", {8'd0, drq}, 9'd0);
        hps_wr = 1'b1; #1;
        chk("rd_wait_fifo_wr", {8'd0, fifo_wr}, 9'd1);
        hps_wr = 1'b0;
        cpu_rd = 1'b1; #1;
        chk("rd_wait_drop_cpu_rd", {8'd0, fifo_rd}, 9'd0);
        cpu_rd = 1'b0;
        fill_sector();
        chk("rd_xfer_irq", {8'd0, irq}, 9'd1);
        chk("rd_xfer_drq", {8'd0, drq}, 9'd1);
        chk("rd_xfer_hps_req", {8'd0, hps_req}, 9'd0);
        cpu_rd = 1'b1; hps_wr = 1'b1; #1;
        chk("rd_xfer_fifo_rd", {8'd0, fifo_rd}, 9'd1);
        chk("rd_xfer_prefetch_wr", {8'd0, fifo_wr}, 9'd1);
        cpu_rd = 1'b0; hps_wr = 1'b0;
        cpu_reads(256, 1'b1);
        chk("rd_sec1_left", sectors_left, 9'd1);
        chk("rd_sec1_hps_req", {8'd0, hps_req}, 9'd1);
        chk("rd_sec1_drq", {8'd0, drq}, 9'd0);
        fill_sector();
        cpu_reads(256, 1'b1);
        chk("rd_done_left", sectors_left, 9'd0);
        chk("rd_done_busy", {8'd0, busy}, 9'd1);
        chk("rd_done_hps_req", {8'd0, hps_req}, 9'd0);
        chk("rd_done_drq", {8'd0, drq}, 9'd0);
        tick();
        chk("rd_idle_busy", {8'd0, busy}, 9'd0);
        chk("rd_idle_irq", {8'd0, irq}, 9'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("irq_ack_clear", {8'd0, irq}, 9'd0);

        // one-sector write
        start(1'b1, 8'd1);
        chk("wr_start_drq", {8'd0, drq}, 9'd1);
        chk("wr_start_irq", {8'd0, irq}, 9'd0);
        chk("wr_start_left", sectors_left, 9'd1);
        cpu_wr = 1'b1; #1;
        chk("wr_fifo_wr", {8'd0, fifo_wr}, 9'd1);
        repeat (255) tick();
        chk("wr_255_drq", {8'd0, drq}, 9'd1);
        tick();
        cpu_wr = 1'b0;
        chk("wr_drain_drq", {8'd0, drq}, 9'd0);
        chk("wr_drain_hps_req", {8'd0, hps_req}, 9'd1);
        cpu_wr = 1'b1; #1;
        chk("wr_drain_drop_cpu_wr", {8'd0, fifo_wr}, 9'd0);
        cpu_wr = 1'b0; hps_rd = 1'b1; #1;
        chk("wr_drain_fifo_rd", {8'd0, fifo_rd}, 9'd1);
        repeat (255) tick();
        fifo_last = 1'b1;
        tick();
        hps_rd = 1'b0; fifo_last = 1'b0;
        chk("wr_done_left", sectors_left, 9'd0);
        chk("wr_done_busy", {8'd0, busy}, 9'd1);
        tick();
        chk("wr_irq", {8'd0, irq}, 9'd1);
        chk("wr_idle_busy", {8'd0, busy}, 9'd0);

        // count 0 means 256, then abort mid-sector
        start(1'b0, 8'd0);
        chk("cnt0_irq_cleared", {8'd0, irq}, 9'd0);
        chk("cnt0_left", sectors_left, 9'd256);
        fill_sector();
        cpu_reads(256, 1'b1);
        chk("cnt0_left_after", sectors_left, 9'd255);
        fill_sector();
        cpu_reads(100, 1'b0);
        chk("pre_abort_left", sectors_left, 9'd255);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_busy", {8'd0, busy}, 9'd0);
        chk("abort_fres", {8'd0, fifo_reset}, 9'd1);
        chk("abort_left", sectors_left, 9'd0);
        chk("abort_drq", {8'd0, drq}, 9'd0);
        chk("abort_irq_kept", {8'd0, irq}, 9'd1);
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle_fres", {8'd0, fifo_reset}, 9'd0);
        chk("abort_idle_irq", {8'd0, irq}, 9'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;

        // simultaneous events
        start(1'b0, 8'd1);
        fifo_full = 1'b1; irq_ack = 1'b1; tick(); fifo_full = 1'b0; irq_ack = 1'b0;
        chk("set_vs_ack_irq", {8'd0, irq}, 9'd1);
        start(1'b1, 8'd5);
        chk("busy_start_left", sectors_left, 9'd1);
        chk("busy_start_drq", {8'd0, drq}, 9'd1);
        chk("busy_start_fres", {8'd0, fifo_reset}, 9'd0);
        chk("busy_start_irq", {8'd0, irq}, 9'd1);
        clk7_en = 1'b0; cpu_rd = 1'b1; fifo_last = 1'b1; abort = 1'b1;
        tick(); tick();
        clk7_en = 1'b1; abort = 1'b0;
        chk("en0_left", sectors_left, 9'd1);
        chk("en0_busy", {8'd0, busy}, 9'd1);
        chk("en0_drq", {8'd0, drq}, 9'd1);
        tick();
        cpu_rd = 1'b0; fifo_last = 1'b0;
        chk("en1_done_left", sectors_left, 9'd0);
        tick();

        // reset mid-transfer beats abort, start and strobes
        start(1'b0, 8'd3);
        reset = 1'b1; abort = 1'b1; hps_wr = 1'b1; fifo_full = 1'b1;
        tick();
        reset = 1'b0; abort = 1'b0; hps_wr = 1'b0; fifo_full = 1'b0;
        chk("midrst_busy", {8'd0, busy}, 9'd0);
        chk("midrst_left", sectors_left, 9'd0);
        chk("midrst_irq", {8'd0, irq}, 9'd0);
        chk("midrst_fres", {8'd0, fifo_reset}, 9'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gayle_xfer_ctrl.md
GAYLE_XFER_CTRL -- requirements
Module: gayle_xfer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, bus clock; reset reset, synchronous, active-high; clock clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled only when clk7_en=1.
REQ-003 SHALL have port clk7_en, input, 1, clock enable; all state changes only when high.
REQ-004 SHALL have ports cmd_start (in, 1, command pulse), cmd_dir (in, 1, 0=disk-to-CPU, 1=CPU-to-disk), cmd_count (in, 8, sector count, 0 means 256).
REQ-005 SHALL have ports abort (in, 1, cancel transfer) and irq_ack (in, 1, clear interrupt).
REQ-006 SHALL have ports cpu_rd and cpu_wr (in, 1 each, CPU data-register strobes), plus hps_rd and hps_wr (in, 1 each, host-side FIFO strobes).
REQ-007 SHALL have ports fifo_full, fifo_empty and fifo_last (in, 1 each, FIFO status: at least one sector held, no data, last word of sector at output).
REQ-008 SHALL have outputs fifo_rd, fifo_wr and fifo_reset (1 each, FIFO controls).
REQ-009 SHALL have outputs drq (1, CPU data request), hps_req (1, host service request), busy (1), irq (1, sticky interrupt) and sectors_left (9, remaining sectors).

Function
REQ-010 SHALL implement states IDLE, RD_WAIT, RD_XFER, WR_XFER, WR_DRAIN and DONE, all transitions qualified by clk7_en.
REQ-011 In IDLE, cmd_start SHALL load sectors_left with cmd_count (0 loads 256), pulse fifo_reset for one enabled cycle, and go to RD_WAIT (dir=0) or WR_XFER (dir=1).
REQ-012 cmd_start SHALL be ignored outside IDLE.
REQ-013 RD_WAIT: hps_req=1 and fifo_wr=hps_wr; on fifo_full=1, go to RD_XFER and set irq.
REQ-014 RD_XFER: drq=1 and fifo_rd=cpu_rd; fifo_wr=hps_wr is still passed so the host can prefetch.
REQ-015 RD_XFER: cpu_rd with fifo_last=1 SHALL decrement sectors_left; go to DONE if the result is 0, else to RD_WAIT.
REQ-016 WR_XFER: drq=1 and fifo_wr=cpu_wr; an internal 8-bit word counter, cleared on entry, counts writes; the 256th write goes to WR_DRAIN.
REQ-017 WR_DRAIN: drq=0, hps_req=1 and fifo_rd=hps_rd; hps_rd with fifo_last=1 SHALL decrement sectors_left; go to DONE if the result is 0, else to WR_XFER and set irq.
REQ-018 DONE: set irq and hps_req=0, then go to IDLE on the next enabled cycle.
REQ-019 busy SHALL be 1 in every state except IDLE; drq, hps_req, fifo_rd and fifo_wr SHALL be combinational from state and strobes, and 0 in IDLE and DONE.
REQ-020 Strobes arriving in states that do not pass them SHALL be dropped with no FIFO effect.
REQ-021 irq SHALL stay high until irq_ack or cmd_start; a set and irq_ack in the same enabled cycle SHALL leave irq=1.
REQ-022 abort in any non-IDLE state SHALL go to IDLE, pulse fifo_reset and zero sectors_left; irq is unchanged; abort in IDLE has no effect.
REQ-023 abort SHALL take priority over every same-cycle transition.
REQ-024 sectors_left SHALL never underflow below 0 or wrap.

Reset
REQ-025 Reset SHALL force IDLE, sectors_left=0, irq=0, word counter=0, fifo_reset=1 for that enabled cycle, and all other outputs 0.
REQ-026 Reset SHALL take priority over abort, cmd_start and any strobe, including reset asserted mid-transfer.

Verification
REQ-027 Read, 2 sectors: start dir=0 count=2; fill with 256 hps_wr -> irq=1, drq=1; 256 cpu_rd -> sectors_left=1, state RD_WAIT; repeat -> DONE, then IDLE with busy=0.
REQ-028 Write, 1 sector: start dir=1 count=1 -> drq=1, no irq; 256 cpu_wr -> drq=0, hps_req=1; 256 hps_rd (last word) -> irq=1, then IDLE.
REQ-029 Count 0: start with cmd_count=0 -> sectors_left=256; after one read sector -> sectors_left=255.
REQ-030 Abort mid-sector: abort after 100 cpu_rd -> next enabled cycle IDLE, fifo_reset=1, sectors_left=0, drq=0.
REQ-031 Simultaneous events: irq_ack in the same cycle as a set -> irq=1; cmd_start while busy -> ignored; clk7_en=0 with strobes -> no state change.
